// File: rtl/cache_pkg.sv
// Shared types for the cache line-replacement controller: FSM state encoding and
// the helper that sizes the beat counter from the line/bus geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // A single-beat line still gets a 1-bit counter so the port never collapses.
    function automatic int unsigned beat_cnt_width(input int unsigned linelen,
                                                   input int unsigned ahbw);
        int unsigned beats;
        beats = linelen / ahbw;
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/cache_evict_if.sv
// Bus handshake between the eviction controller (master) and the memory bus
// (slave): request, direction, beat index and per-beat acknowledge.
interface cache_evict_if #(
    parameter int unsigned CNTW = 3
);
    logic            BusReq;
    logic            BusWrite;
    logic            BusAck;
    logic [CNTW-1:0] BeatCount;

    modport master (
        output BusReq,
        output BusWrite,
        output BeatCount,
        input  BusAck
    );

    modport slave (
        input  BusReq,
        input  BusWrite,
        input  BeatCount,
        output BusAck
    );
endinterface

// File: rtl/beatcounter.sv
// Enabled beat counter with synchronous wrap at BEATS-1 and a last-beat flag;
// asynchronous active-high reset.
module beatcounter #(
    parameter int unsigned BEATS = 8,
    parameter int unsigned CNTW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [CNTW-1:0] count,
    output logic            last
);

    assign last = (count == CNTW'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CNTW'(1);
        end
    end

endmodule

// File: rtl/cache_evict.sv
// Cache line-replacement controller: optional dirty-victim writeback, line fetch,
// then valid/dirty/LRU update pulses. Writeback support is built with CACHE_WRITEBACK_EN.
module cache_evict
    import cache_pkg::*;
#(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned LINELEN = 256,
    parameter int unsigned AHBW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic               Miss,
    input  logic [NUMWAYS-1:0] VictimWay,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    cache_evict_if.master      bus,
    output logic [NUMWAYS-1:0] SelWay,
    output logic               FillWordEn,
    output logic               SetValid,
    output logic               ClearDirty,
    output logic               LRUWriteEn,
    output logic               Stall
);

    localparam int unsigned BEATS = LINELEN / AHBW;
    localparam int unsigned CNTW  = beat_cnt_width(LINELEN, AHBW);

    state_t             state_q, state_d;
    logic [NUMWAYS-1:0] sel_q, sel_d;
    logic               accept;
    logic               wb_needed;
    logic               cnt_en;
    logic               cnt_last;
    logic [CNTW-1:0]    cnt;
    logic               bus_req;
    logic               bus_write;
    logic               fill_en;
    logic               set_valid;
    logic               clear_dirty;
    logic               lru_we;

    assign accept = (state_q == READY) & Miss & ~FlushStage;

`ifdef CACHE_WRITEBACK_EN
    assign wb_needed = |(VictimWay & ValidWay & DirtyWay);
`else
    // Write-through: victim lines are never dirty, so the set state is irrelevant.
    logic unused_set_bits;
    assign wb_needed       = 1'b0;
    assign unused_set_bits = ^{ValidWay, DirtyWay};
`endif

    beatcounter #(
        .BEATS (BEATS),
        .CNTW  (CNTW)
    ) u_beatcounter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READY;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        bus_req     = 1'b0;
        bus_write   = 1'b0;
        fill_en     = 1'b0;
        set_valid   = 1'b0;
        clear_dirty = 1'b0;
        lru_we      = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            READY: begin
                if (accept) begin
                    sel_d   = VictimWay;
                    state_d = wb_needed ? WRITEBACK : FETCH;
                end
            end
`ifdef CACHE_WRITEBACK_EN
            WRITEBACK: begin
                bus_req   = 1'b1;
                bus_write = 1'b1;
                cnt_en    = bus.BusAck;
                if (bus.BusAck && cnt_last) begin
                    state_d = FETCH;
                end
            end
`endif
            FETCH: begin
                bus_req = 1'b1;
                cnt_en  = bus.BusAck;
                fill_en = bus.BusAck;
                if (bus.BusAck && cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                set_valid = 1'b1;
                lru_we    = 1'b1;
`ifdef CACHE_WRITEBACK_EN
                clear_dirty = 1'b1;
`endif
                state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    assign bus.BusReq    = bus_req;
    assign bus.BusWrite  = bus_write;
    assign bus.BeatCount = cnt;
    assign SelWay        = sel_q;
    assign FillWordEn    = fill_en;
    assign SetValid      = set_valid;
    assign ClearDirty    = clear_dirty;
    assign LRUWriteEn    = lru_we;
    // Gated by reset so the pipeline is released the moment reset asserts.
    assign Stall         = ~reset & ((state_q != READY) | accept);

    a_victim_onehot: assert property (@(posedge clk) disable iff (reset)
        accept |-> $onehot(VictimWay));

endmodule

// File: tb/tb_cache_evict.sv
module tb_cache_evict;
    import cache_pkg::*;

    localparam int unsigned NW = 4;
    localparam int unsigned LL = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = beat_cnt_width(LL, AW);
`ifdef CACHE_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          FlushStage;
    logic          Miss;
    logic [NW-1:0] VictimWay;
    logic [NW-1:0] ValidWay;
    logic [NW-1:0] DirtyWay;
    logic [NW-1:0] SelWay;
    logic          FillWordEn;
    logic          SetValid;
    logic          ClearDirty;
    logic          LRUWriteEn;
    logic          Stall;

    int total = 0;
    int bad   = 0;

    cache_evict_if #(.CNTW(CW)) bus ();

    cache_evict #(
        .NUMWAYS (NW),
        .LINELEN (LL),
        .AHBW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .FlushStage (FlushStage),
        .Miss       (Miss),
        .VictimWay  (VictimWay),
        .ValidWay   (ValidWay),
        .DirtyWay   (DirtyWay),
        .bus        (bus),
        .SelWay     (SelWay),
        .FillWordEn (FillWordEn),
        .SetValid   (SetValid),
        .ClearDirty (ClearDirty),
        .LRUWriteEn (LRUWriteEn),
        .Stall      (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input string tag, input logic [3:0] vic, input logic [3:0] dirty,
                           input bit toggle, input bit flush_mid, input bit keep_miss,
                           input int exp_stall);
        int   wb_n;
        int   f_n;
        int   stall_n;
        int   exp_beat;
        logic ack;
        wb_n = (WB_EN && ((vic & ValidWay & dirty) != 4'b0000)) ? 8 : 0;
        f_n  = toggle ? 15 : 8;
        VictimWay  = vic;
        DirtyWay   = dirty;
        bus.BusAck = 1'b1;
        FlushStage = 1'b0;
        Miss       = 1'b1;
        #1;
        chk({tag, ".acc_stall"}, 32'(Stall), 32'(1));
        chk({tag, ".acc_busreq"}, 32'(bus.BusReq), 32'(0));
        stall_n = 1;
        for (int k = 1; k <= wb_n; k++) begin
            tick();
            total++;
            if (bus.BusReq !== 1'b1) begin
                bad++;
                $error("FAIL %s.wb_busreq k=%0d observed=%b", tag, k, bus.BusReq);
            end
            total++;
            if (bus.BusWrite !== 1'b1) begin
                bad++;
                $error("FAIL %s.wb_buswrite k=%0d observed=%b", tag, k, bus.BusWrite);
            end
            total++;
            if (bus.BeatCount !== CW'(k - 1)) begin
                bad++;
                $error("FAIL %s.wb_beat k=%0d observed=%0d", tag, k, bus.BeatCount);
            end
            total++;
            if (FillWordEn !== 1'b0) begin
                bad++;
                $error("FAIL %s.wb_fill k=%0d observed=%b", tag, k, FillWordEn);
            end
            if (Stall === 1'b1) stall_n++;
        end
        for (int k = 1; k <= f_n; k++) begin
            tick();
            ack = toggle ? ((k % 2) == 1) : 1'b1;
            bus.BusAck = ack;
            FlushStage = flush_mid;
            #1;
            exp_beat = toggle ? (k / 2) : (k - 1);
            total++;
            if (bus.BusReq !== 1'b1) begin
                bad++;
                $error("FAIL %s.f_busreq k=%0d observed=%b", tag, k, bus.BusReq);
            end
            total++;
            if (bus.BusWrite !== 1'b0) begin
                bad++;
                $error("FAIL %s.f_buswrite k=%0d observed=%b", tag, k, bus.BusWrite);
            end
            total++;
            if (bus.BeatCount !== CW'(exp_beat)) begin
                bad++;
                $error("FAIL %s.f_beat k=%0d observed=%0d expected=%0d", tag, k,
                       bus.BeatCount, exp_beat);
            end
            total++;
            if (FillWordEn !== ack) begin
                bad++;
                $error("FAIL %s.f_fill k=%0d observed=%b expected=%b", tag, k, FillWordEn, ack);
            end
            if (Stall === 1'b1) stall_n++;
        end
        tick();
        FlushStage = 1'b0;
        chk({tag, ".done_setvalid"}, 32'(SetValid), 32'(1));
        chk({tag, ".done_lru"}, 32'(LRUWriteEn), 32'(1));
        chk({tag, ".done_cleardirty"}, 32'(ClearDirty), 32'(WB_EN));
        chk({tag, ".done_selway"}, 32'(SelWay), 32'(vic));
        chk({tag, ".done_busreq"}, 32'(bus.BusReq), 32'(0));
        if (Stall === 1'b1) stall_n++;
        Miss = keep_miss;
        tick();
        chk({tag, ".post_stall"}, 32'(Stall), 32'(keep_miss));
        chk({tag, ".post_setvalid"}, 32'(SetValid), 32'(0));
        chk({tag, ".post_busreq"}, 32'(bus.BusReq), 32'(0));
        chk({tag, ".stall_len"}, 32'(stall_n), 32'(exp_stall));
    endtask

    initial begin
        reset      = 1'b0;
        FlushStage = 1'b0;
        Miss       = 1'b0;
        VictimWay  = 4'b0000;
        ValidWay   = 4'b1111;
        DirtyWay   = 4'b0000;
        bus.BusAck = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++;
        if (Stall !== 1'b0) begin
            bad++;
            $error("FAIL rst.stall observed=%b", Stall);
        end
        total++;
        if (bus.BusReq !== 1'b0) begin
            bad++;
            $error("FAIL rst.busreq observed=%b", bus.BusReq);
        end
        total++;
        if (bus.BusWrite !== 1'b0) begin
            bad++;
            $error("FAIL rst.buswrite observed=%b", bus.BusWrite);
        end
        total++;
        if (bus.BeatCount !== CW'(0)) begin
            bad++;
            $error("FAIL rst.beat observed=%0d", bus.BeatCount);
        end
        total++;
        if (SelWay !== 4'b0000) begin
            bad++;
            $error("FAIL rst.selway observed=%b", SelWay);
        end
        chk("rst.setvalid", 32'(SetValid), 32'(0));
        chk("rst.fill", 32'(FillWordEn), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();

        do_miss("clean", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 10);
        do_miss("dirty", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, WB_EN ? 18 : 10);
        do_miss("dirty_other", 4'b0010, 4'b0101, 1'b0, 1'b0, 1'b0, 10);
        do_miss("dirty_all", 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, WB_EN ? 18 : 10);
        do_miss("ack_toggle", 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 17);

        DirtyWay   = 4'b0000;
        VictimWay  = 4'b0001;
        FlushStage = 1'b1;
        Miss       = 1'b1;
        #1;
        chk("flush.stall", 32'(Stall), 32'(0));
        chk("flush.busreq", 32'(bus.BusReq), 32'(0));
        tick();
        chk("flush.stall2", 32'(Stall), 32'(0));
        chk("flush.busreq2", 32'(bus.BusReq), 32'(0));
        chk("flush.selway", 32'(SelWay), 32'(4'b1000));
        Miss       = 1'b0;
        FlushStage = 1'b0;
        tick();

        do_miss("flush_mid", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 10);

        do_miss("b2b_a", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 10);
        do_miss("b2b_b", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 10);

        VictimWay  = 4'b0100;
        DirtyWay   = 4'b0100;
        bus.BusAck = 1'b1;
        Miss       = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid.beat", 32'(bus.BeatCount), 32'(3));
        chk("mid.busreq", 32'(bus.BusReq), 32'(1));
        chk("mid.buswrite", 32'(bus.BusWrite), 32'(WB_EN));
        reset = 1'b1;
        Miss  = 1'b0;
        #1;
        total++;
        if (bus.BusReq !== 1'b0) begin
            bad++;
            $error("FAIL mid_rst.busreq observed=%b", bus.BusReq);
        end
        total++;
        if (Stall !== 1'b0) begin
            bad++;
            $error("FAIL mid_rst.stall observed=%b", Stall);
        end
        total++;
        if (bus.BeatCount !== CW'(0)) begin
            bad++;
            $error("FAIL mid_rst.beat observed=%0d", bus.BeatCount);
        end
        chk("mid_rst.selway", 32'(SelWay), 32'(0));
        tick();
        reset = 1'b0;
        #1;
        chk("rel.stall", 32'(Stall), 32'(0));
        chk("rel.busreq", 32'(bus.BusReq), 32'(0));
        tick();
        chk("rel.busreq2", 32'(bus.BusReq), 32'(0));
        chk("rel.beat", 32'(bus.BeatCount), 32'(0));
        DirtyWay = 4'b0000;
        do_miss("after_rst", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
